// File: rtl/uart_pkg.sv
// Shared UART constants and elaboration helpers used by the baud generator
// and the UART TX/RX blocks.
package uart_pkg;

    localparam int UART_CLOCK_IN          = 100_000_000;
    localparam int UART_BAUD_RATE         = 230_400;
    localparam int UART_OVERSAMPLING_RATE = 8;

    // Accumulator width that holds acc + num for any acc in [0, den-1].
    function automatic int phase_width(input longint unsigned num, input longint unsigned den);
        return $clog2(num + den);
    endfunction

endpackage

// File: rtl/frac_pulse_divider.sv
// Fractional phase accumulator: emits a one-cycle PULSE at an average rate of
// NUM/DEN per clock, with no long-term drift.
module frac_pulse_divider
    import uart_pkg::*;
#(
    parameter int NUM = UART_BAUD_RATE * UART_OVERSAMPLING_RATE,
    parameter int DEN = UART_CLOCK_IN
) (
    input  logic CLK,
    input  logic RST,
    output logic PULSE,
    // Overflow on the coming edge; lets the parent advance counters in step with PULSE.
    output logic WRAP
);

    localparam int W = phase_width(longint'(NUM), longint'(DEN));
    localparam logic [W-1:0] NUM_W = W'(NUM);
    localparam logic [W-1:0] DEN_W = W'(DEN);

    if (NUM <= 0 || NUM > DEN) begin : g_bad_ratio
        $error("frac_pulse_divider: NUM must be in 1..DEN");
    end

    logic [W-1:0] acc;
    logic [W-1:0] sum;

    assign sum  = acc + NUM_W;
    assign WRAP = (sum >= DEN_W);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; reset here is synchronous, sampled on CLK.
    always_ff @(posedge CLK) begin
        if (RST) begin
            acc   <= '0;
            PULSE <= 1'b0;
        end else if (WRAP) begin
            acc   <= sum - DEN_W;
            PULSE <= 1'b1;
        end else begin
            acc   <= sum;
            PULSE <= 1'b0;
        end
    end

endmodule

// File: rtl/baud_generator.sv
// UART pulse-rate generator: DIVPULSE at BAUD_RATE*OVERSAMPLING_RATE for the
// RX sampler, BAUDPULSE on every OVERSAMPLING_RATE-th DIVPULSE for TX.
module baud_generator
    import uart_pkg::*;
#(
    parameter int BAUD_RATE         = UART_BAUD_RATE,
    parameter int CLOCK_IN          = UART_CLOCK_IN,
    parameter int OVERSAMPLING_RATE = UART_OVERSAMPLING_RATE
) (
    input  logic CLK,
    input  logic RST,
    output logic DIVPULSE,
    output logic BAUDPULSE
);

    localparam longint INC_L = longint'(BAUD_RATE) * longint'(OVERSAMPLING_RATE);
    localparam int     INC   = int'(INC_L);
    localparam int     CW    = (OVERSAMPLING_RATE > 1) ? $clog2(OVERSAMPLING_RATE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLING_RATE - 1);

    if (OVERSAMPLING_RATE < 1 || INC_L <= 0 || INC_L > longint'(CLOCK_IN)) begin : g_bad_params
        $error("baud_generator: need OVERSAMPLING_RATE >= 1 and 0 < BAUD_RATE*OVERSAMPLING_RATE <= CLOCK_IN");
    end

    logic          wrap;
    logic [CW-1:0] cnt;

    frac_pulse_divider #(
        .NUM (INC),
        .DEN (CLOCK_IN)
    ) u_div (
        .CLK   (CLK),
        .RST   (RST),
        .PULSE (DIVPULSE),
        .WRAP  (wrap)
    );

    // Count advances only on overflow edges, so BAUDPULSE lands on the same
    // cycle as the DIVPULSE that completes each group.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt       <= '0;
            BAUDPULSE <= 1'b0;
        end else if (wrap) begin
            if (cnt == CNT_LAST) begin
                cnt       <= '0;
                BAUDPULSE <= 1'b1;
            end else begin
                cnt       <= cnt + CW'(1);
                BAUDPULSE <= 1'b0;
            end
        end else begin
            BAUDPULSE <= 1'b0;
        end
    end

endmodule

// File: tb/tb_baud_generator.sv
// Bench for baud_generator: four parameter sets driven from one reset, each
// compared every cycle against floor(k*rate/clock) arithmetic.
module tb_baud_generator;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic div_def,  baud_def;
    logic div_int,  baud_int;
    logic div_one,  baud_one;
    logic div_full, baud_full;

    always #5 clk = ~clk;

    baud_generator u_def (
        .CLK(clk), .RST(rst), .DIVPULSE(div_def), .BAUDPULSE(baud_def)
    );

    baud_generator #(.BAUD_RATE(1_000_000), .CLOCK_IN(16_000_000), .OVERSAMPLING_RATE(4)) u_int (
        .CLK(clk), .RST(rst), .DIVPULSE(div_int), .BAUDPULSE(baud_int)
    );

    baud_generator #(.BAUD_RATE(7_000_000), .CLOCK_IN(100_000_000), .OVERSAMPLING_RATE(1)) u_one (
        .CLK(clk), .RST(rst), .DIVPULSE(div_one), .BAUDPULSE(baud_one)
    );

    baud_generator #(.BAUD_RATE(12_500_000), .CLOCK_IN(100_000_000), .OVERSAMPLING_RATE(8)) u_full (
        .CLK(clk), .RST(rst), .DIVPULSE(div_full), .BAUDPULSE(baud_full)
    );

    int total = 0;
    int bad   = 0;

    // Edges with RST=0 since the last reset edge.
    longint k = 0;
    bit     checking = 1'b0;

    int cnt_div, cnt_baud, first_div, first_baud, div_at_first_baud;
    int last_div, min_gap, max_gap, wide;
    int cnt_div_int, cnt_baud_int, cnt_div_full, cnt_baud_full;
    bit prev_div;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // A pulse follows edge k exactly when floor(k*rate/clock) steps up at k.
    function automatic logic hit(input longint kk, input longint rate, input longint clock_in);
        if (kk <= 0) return 1'b0;
        return ((kk * rate) / clock_in) != (((kk - 1) * rate) / clock_in);
    endfunction

    task automatic clear_stats();
        cnt_div = 0; cnt_baud = 0; first_div = -1; first_baud = -1; div_at_first_baud = -1;
        last_div = -1; min_gap = 1 << 30; max_gap = 0; wide = 0; prev_div = 1'b0;
        cnt_div_int = 0; cnt_baud_int = 0; cnt_div_full = 0; cnt_baud_full = 0;
    endtask

    task automatic check_all();
        check("def_div",   div_def,   hit(k, 64'd1_843_200, 64'd100_000_000));
        check("def_baud",  baud_def,  hit(k, 64'd230_400, 64'd100_000_000));
        check("int_div",   div_int,   hit(k, 64'd4_000_000, 64'd16_000_000));
        check("int_baud",  baud_int,  hit(k, 64'd1_000_000, 64'd16_000_000));
        check("one_div",   div_one,   hit(k, 64'd7_000_000, 64'd100_000_000));
        check("one_baud",  baud_one,  hit(k, 64'd7_000_000, 64'd100_000_000));
        check("one_equiv", baud_one,  div_one);
        check("full_div",  div_full,  hit(k, 64'd100_000_000, 64'd100_000_000));
        check("full_baud", baud_full, hit(k, 64'd12_500_000, 64'd100_000_000));
    endtask

    task automatic cycle();
        logic r;
        r = rst;
        @(posedge clk);
        #1;
        if (r) k = 0;
        else   k++;
        if (!checking) return;
        check_all();
        if (r) return;
        if (div_def === 1'b1) begin
            cnt_div++;
            if (first_div < 0) first_div = int'(k);
            if (last_div >= 0) begin
                if (int'(k) - last_div < min_gap) min_gap = int'(k) - last_div;
                if (int'(k) - last_div > max_gap) max_gap = int'(k) - last_div;
            end
            last_div = int'(k);
            if (prev_div) wide++;
        end
        prev_div = (div_def === 1'b1);
        if (baud_def === 1'b1) begin
            cnt_baud++;
            if (first_baud < 0) begin
                first_baud        = int'(k);
                div_at_first_baud = cnt_div;
            end
        end
        if (div_int === 1'b1)   cnt_div_int++;
        if (baud_int === 1'b1)  cnt_baud_int++;
        if (div_full === 1'b1)  cnt_div_full++;
        if (baud_full === 1'b1) cnt_baud_full++;
    endtask

    initial begin
        clear_stats();

        // Reset sequence: two idle cycles before any reset, then two reset cycles.
        #1;
        rst = 1'b0;
        repeat (2) cycle();
        rst = 1'b1;
        checking = 1'b1;
        repeat (2) cycle();
        check("rst_div_low",  div_def,  1'b0);
        check("rst_baud_low", baud_def, 1'b0);

        // Release and run 10_000 cycles: rate, gaps, widths, first pulses.
        rst = 1'b0;
        clear_stats();
        repeat (10_000) cycle();
        check("first_div_edge",      first_div,         55);
        check("first_baud_edge",     first_baud,        435);
        check("div_at_first_baud",   div_at_first_baud, 8);
        check("div_count_10k",       cnt_div,           184);
        check("baud_count_10k",      cnt_baud,          23);
        check("min_div_gap",         min_gap,           54);
        check("max_div_gap",         max_gap,           55);
        check("wide_div_pulses",     wide,              0);
        check("int_div_count_10k",   cnt_div_int,       2500);
        check("int_baud_count_10k",  cnt_baud_int,      625);
        check("full_div_count_10k",  cnt_div_full,      10_000);
        check("full_baud_count_10k", cnt_baud_full,     1250);

        // Mid-operation reset at cycle 300: the sequence restarts from scratch.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (300) cycle();
        rst = 1'b1;
        cycle();
        check("mid_rst_div_low",  div_def,  1'b0);
        check("mid_rst_baud_low", baud_def, 1'b0);
        rst = 1'b0;
        clear_stats();
        repeat (500) cycle();
        check("mid_first_div_edge",  first_div,  55);
        check("mid_first_baud_edge", first_baud, 435);

        // Random run lengths and reset holds, checked against the model each cycle.
        for (int i = 0; i < 15; i++) begin
            int run_len;
            int hold;
            run_len = $urandom_range(1, 1200);
            hold    = $urandom_range(1, 4);
            repeat (run_len) cycle();
            rst = 1'b1;
            repeat (hold) cycle();
            check("rand_rst_div_low",  div_def,   1'b0);
            check("rand_rst_baud_low", baud_full, 1'b0);
            rst = 1'b0;
        end
        repeat (50) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/baud_generator.md
# baud_generator

Pulse-rate generator for the UART block. It produces two single-cycle strobes: DIVPULSE at BAUD_RATE × OVERSAMPLING_RATE for the RX oversampling sampler, and BAUDPULSE at BAUD_RATE for the TX bit timer. Both come from one system clock through a fractional phase accumulator, so the average rate is exact even when the clock is not an integer multiple of the target rate.

## Interface
- BAUD_RATE, default 230_400: target bit rate in baud.
- CLOCK_IN, default 100_000_000: CLK frequency in Hz.
- OVERSAMPLING_RATE, default 8: number of DIVPULSEs per BAUDPULSE; must be ≥ 1.
- CLK  input  1  system clock; all logic is rising-edge.
- RST  input  1  reset; one clock, and reset is synchronous and active-high.
- DIVPULSE  output  1  one-cycle strobe at BAUD_RATE × OVERSAMPLING_RATE on average.
- BAUDPULSE  output  1  one-cycle strobe on every OVERSAMPLING_RATE-th DIVPULSE.

## Operation
- Constant INC = BAUD_RATE × OVERSAMPLING_RATE.
- Elaboration-time error if INC > CLOCK_IN, if INC = 0, or if OVERSAMPLING_RATE < 1.
- Phase accumulator ACC runs from 0 to CLOCK_IN−1.
  - ACC width: $clog2(CLOCK_IN + INC) bits.
  - All arithmetic is unsigned at that width, with no truncation.
- Each non-reset edge:
  - If ACC + INC ≥ CLOCK_IN: ACC ← ACC + INC − CLOCK_IN, and DIVPULSE ← 1.
  - Otherwise: ACC ← ACC + INC, and DIVPULSE ← 0.
- Oversample counter CNT runs from 0 to OVERSAMPLING_RATE−1 and updates only on edges where the accumulator overflows.
  - If CNT = OVERSAMPLING_RATE−1: CNT ← 0, and BAUDPULSE ← 1.
  - Otherwise: CNT ← CNT+1.
  - On all other edges BAUDPULSE ← 0.
- With OVERSAMPLING_RATE = 1, BAUDPULSE is identical to DIVPULSE.
- With INC = CLOCK_IN, DIVPULSE is high on every cycle after reset.
- Spacing between consecutive DIVPULSEs is ⌊CLOCK_IN/INC⌋ or ⌈CLOCK_IN/INC⌉ cycles. The long-run average is exactly CLOCK_IN/INC.

## Timing
- Both outputs are registered and there is no combinational path from any input.
- Reset: an edge with RST=1 sets ACC=0, CNT=0, DIVPULSE=0 and BAUDPULSE=0. These values are visible after that edge.
- Reset mid-operation behaves identically, and any pending fractional phase is discarded.
- Holding RST high for any number of cycles keeps both outputs at 0.
- Let edge k be the k-th rising edge with RST=0 after reset.
  - DIVPULSE goes high after edge k exactly when ⌊k·INC/CLOCK_IN⌋ increments at k.
  - BAUDPULSE is high in the same cycle as every OVERSAMPLING_RATE-th DIVPULSE.
- Each pulse lasts exactly one CLK cycle.
- Defaults: INC = 1_843_200, so the mean DIVPULSE period is 54.25 cycles and the mean BAUDPULSE period is 434.03 cycles.
  - First DIVPULSE after edge 55; then after edges 109, 163, 218.
  - Gap pattern from the first pulse: 55, 54, 54, 55, …
  - First BAUDPULSE after edge 435, coincident with the 8th DIVPULSE.

## Structure
- Shared package uart_pkg: default constants UART_CLOCK_IN, UART_BAUD_RATE and UART_OVERSAMPLING_RATE, used by this block and by the UART TX/RX.
- Sub-module frac_pulse_divider:
  - Parameters NUM (=INC) and DEN (=CLOCK_IN).
  - Ports CLK, RST and PULSE.
  - Contains the phase accumulator.
- The top level instantiates frac_pulse_divider and adds the oversample counter and BAUDPULSE register.

## Test plan
- **Reset sequence.** Defaults; RST=0 for 2 cycles, RST=1 for 2 cycles, then released → both outputs 0 during reset. First DIVPULSE after the 55th post-release edge; first BAUDPULSE after edge 435, coincident with DIVPULSE #8.
- **Rate count.** Defaults; run 10_000 cycles after release → exactly 184 DIVPULSEs and 23 BAUDPULSEs. Every DIVPULSE gap is 54 or 55 cycles. Every pulse is 1 cycle wide.
- **Mid-operation reset.** Assert RST for 1 cycle at cycle 300 → outputs 0 next cycle. The next DIVPULSE comes 55 edges after release and the next BAUDPULSE 435 edges after release, i.e. the sequence restarts.
- **Integer division.** BAUD_RATE=1_000_000, CLOCK_IN=16_000_000, OVERSAMPLING_RATE=4 → DIVPULSE every exactly 4 cycles; BAUDPULSE every 16 cycles, coincident with every 4th DIVPULSE.
- **Degenerate parameters.**
  - OVERSAMPLING_RATE=1 → BAUDPULSE ≡ DIVPULSE.
  - INC = CLOCK_IN (e.g. BAUD_RATE=12_500_000, OVERSAMPLING_RATE=8, CLOCK_IN=100_000_000) → DIVPULSE constantly 1 from edge 1; BAUDPULSE every 8 cycles.
